// File: rtl/cancel_pkg.sv
// Shared types for the upstream cancel transmitter.
package cancel_pkg;

  localparam int NUM_CLIENTS = 32;

  typedef logic [4:0]  client_id_t;
  typedef logic [31:0] amount_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    WAIT_ACK = 2'd2
  } tx_state_t;

endpackage

// File: rtl/cancel_req_fifo.sv
// Request FIFO for cancel messages; DEPTH must be a power of two, >= 2.
// A push while full is dropped unless a pop happens in the same cycle.
module cancel_req_fifo
  import cancel_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  client_id_t push_id_i,
  input  amount_t    push_amt_i,
  input  logic       pop_i,
  output client_id_t head_id_o,
  output amount_t    head_amt_o,
  output logic       empty_o,
  output logic       full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  client_id_t      id_mem_q  [DEPTH];
  amount_t         amt_mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign do_pop     = pop_i && !empty_o;
  assign do_push    = push_i && (!full_o || do_pop);
  assign head_id_o  = id_mem_q[rd_ptr_q];
  assign head_amt_o = amt_mem_q[rd_ptr_q];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) begin
      id_mem_q[wr_ptr_q]  <= push_id_i;
      amt_mem_q[wr_ptr_q] <= push_amt_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/upstream_cancel_tx.sv
// Upstream cancel transmitter: queues cancel requests, presents them one at
// a time downstream and accumulates acknowledged amounts per client.
// Optional feature macro: UPSTREAM_RETRY_EN (timeout, retransmit and drop).
//
// state    | meaning
// IDLE     | nothing in flight, waiting for a queued request
// LOAD     | pop FIFO head into the holding registers
// WAIT_ACK | message presented (tx_valid) until ack, or retried/dropped
module upstream_cancel_tx
  import cancel_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_client_id,
  input  logic [31:0] req_amount,
  output logic        tx_valid,
  output logic [4:0]  tx_client_id,
  output logic [31:0] tx_amount,
  input  logic        ack,
  input  logic [4:0]  rd_client_id,
  output logic [31:0] rd_total_sent,
  output logic        drop_pulse,
  output logic        busy
);

  tx_state_t  state_q, state_d;
  logic       txv_q, txv_d;
  client_id_t txid_q, txid_d;
  amount_t    txamt_q, txamt_d;
  amount_t    table_q [NUM_CLIENTS];
  logic       fifo_empty, fifo_full, fifo_pop, ack_take, msg_done;
  client_id_t head_id;
  amount_t    head_amt;

`ifdef UPSTREAM_RETRY_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          drop_q, drop_d;
  assign drop_pulse = drop_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, MAX_RETRY};
  assign drop_pulse = 1'b0;
`endif

  // Holding reset low also keeps the request port closed.
  assign req_ready     = rst_n && !fifo_full;
  assign busy          = (state_q != IDLE) || !fifo_empty;
  assign tx_valid      = txv_q;
  assign tx_client_id  = txid_q;
  assign tx_amount     = txamt_q;
  assign rd_total_sent = table_q[rd_client_id];

  cancel_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (req_valid && req_ready),
    .push_id_i  (req_client_id),
    .push_amt_i (req_amount),
    .pop_i      (fifo_pop),
    .head_id_o  (head_id),
    .head_amt_o (head_amt),
    .empty_o    (fifo_empty),
    .full_o     (fifo_full)
  );

  // Next-state, holding-register and retry decisions.
  always_comb begin
    state_d  = state_q;
    txv_d    = txv_q;
    txid_d   = txid_q;
    txamt_d  = txamt_q;
    fifo_pop = 1'b0;
    ack_take = 1'b0;
    msg_done = 1'b0;
`ifdef UPSTREAM_RETRY_EN
    tmo_d    = tmo_q;
    retry_d  = retry_q;
    drop_d   = 1'b0;
`endif
    case (state_q)
      IDLE: if (!fifo_empty) state_d = LOAD;
      LOAD: begin
        fifo_pop = 1'b1;
        txid_d   = head_id;
        txamt_d  = head_amt;
        txv_d    = 1'b1;
        state_d  = WAIT_ACK;
      end
      WAIT_ACK: begin
        // ack only counts while the message is actually presented.
        if (txv_q && ack) begin
          ack_take = 1'b1;
          msg_done = 1'b1;
        end
`ifdef UPSTREAM_RETRY_EN
        else if (txv_q) begin
          if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d = '0;
            txv_d = 1'b0;
            if (retry_q == RW'(MAX_RETRY)) begin
              drop_d   = 1'b1;
              msg_done = 1'b1;
            end else begin
              retry_d = retry_q + 1'b1;
            end
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end else begin
          // Single low gap done; re-present the same message.
          txv_d = 1'b1;
        end
`endif
        if (msg_done) begin
          txv_d   = 1'b0;
          state_d = fifo_empty ? IDLE : LOAD;
`ifdef UPSTREAM_RETRY_EN
          tmo_d   = '0;
          retry_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and holding registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      txv_q   <= 1'b0;
      txid_q  <= '0;
      txamt_q <= '0;
`ifdef UPSTREAM_RETRY_EN
      tmo_q   <= '0;
      retry_q <= '0;
      drop_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      txv_q   <= txv_d;
      txid_q  <= txid_d;
      txamt_q <= txamt_d;
`ifdef UPSTREAM_RETRY_EN
      tmo_q   <= tmo_d;
      retry_q <= retry_d;
      drop_q  <= drop_d;
`endif
    end
  end

  // Per-client acknowledged totals, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLIENTS; i++) table_q[i] <= '0;
    end else if (ack_take) begin
      table_q[txid_q] <= table_q[txid_q] + txamt_q;
    end
  end

endmodule

// File: tb/tb_upstream_cancel_tx.sv
// Self-checking bench for upstream_cancel_tx; honours UPSTREAM_RETRY_EN.
module tb_upstream_cancel_tx;

  localparam int TIMEOUT = 16;

  typedef struct packed {
    logic [4:0]  id;
    logic [31:0] amt;
  } msg_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_client_id = '0;
  logic [31:0] req_amount = '0;
  logic        tx_valid;
  logic [4:0]  tx_client_id;
  logic [31:0] tx_amount;
  logic        ack = 1'b0;
  logic [4:0]  rd_client_id = '0;
  logic [31:0] rd_total_sent;
  logic        drop_pulse;
  logic        busy;

  int   total = 0;
  int   bad = 0;
  msg_t sbq[$];
  bit   sb_en = 1'b1;
  int   ack_mode = 0;
  bit   prev_txv = 1'b0;
  int   rise_cnt = 0, drop_cnt = 0, gap_bad = 0, hi_bad = 0;
  int   hi_run = 0, lo_run = 0;
  int   waited;

  upstream_cancel_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_client_id (req_client_id),
    .req_amount    (req_amount),
    .tx_valid      (tx_valid),
    .tx_client_id  (tx_client_id),
    .tx_amount     (tx_amount),
    .ack           (ack),
    .rd_client_id  (rd_client_id),
    .rd_total_sent (rd_total_sent),
    .drop_pulse    (drop_pulse),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor: scoreboard on each new presentation, shape counters, ack driver.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_txv = 1'b0;
      hi_run   = 0;
      lo_run   = 0;
      ack      = 1'b0;
    end else begin
      if (tx_valid && !prev_txv) begin
        rise_cnt++;
        if (rise_cnt > 1 && lo_run != 1) gap_bad++;
        if (sb_en) begin
          check("sb_has_entry", 64'(sbq.size() != 0), 64'd1);
          if (sbq.size() != 0) begin
            msg_t m;
            m = sbq.pop_front();
            check("tx_client_id", 64'(tx_client_id), 64'(m.id));
            check("tx_amount", 64'(tx_amount), 64'(m.amt));
          end
        end
      end
      if (tx_valid) begin
        hi_run++;
        lo_run = 0;
      end else begin
        if (prev_txv && hi_run != TIMEOUT) hi_bad++;
        hi_run = 0;
        lo_run++;
      end
      if (drop_pulse) drop_cnt++;
      prev_txv = tx_valid;
      case (ack_mode)
        1:       ack = tx_valid;
        2:       ack = !tx_valid;
        default: ack = 1'b0;
      endcase
    end
  end

  task automatic push(input logic [4:0] id, input logic [31:0] amt, output int w);
    msg_t m;
    @(negedge clk);
    req_valid     = 1'b1;
    req_client_id = id;
    req_amount    = amt;
    w = 0;
    while (!req_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      check("push_timeout", 64'(req_ready), 64'd1);
    end else begin
      @(posedge clk);
      m.id  = id;
      m.amt = amt;
      sbq.push_back(m);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd0);
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_drop", 64'(drop_pulse), 64'd0);
    check("rst_total", 64'(rd_total_sent), 64'd0);
    rst_n = 1'b1;
    #1 check("ready_after_release", 64'(req_ready), 64'd1);

    // Single request: latency, pre-update read on ack cycle, post-update read
    ack_mode = 1;
    rd_client_id = 5'h1B;
    push(5'h1B, 32'hC5, waited);
    @(negedge clk);
    @(negedge clk);
    check("lat_not_early", 64'(tx_valid), 64'd0);
    @(negedge clk);
    check("lat_tx_valid", 64'(tx_valid), 64'd1);
    check("total_pre_update", 64'(rd_total_sent), 64'd0);
    @(negedge clk);
    check("total_single", 64'(rd_total_sent), 64'hC5);
    wait_idle("idle_single");

    // Back-to-back same client
    do_reset();
    push(5'h1B, 32'hC5, waited);
    push(5'h1B, 32'hC5, waited);
    wait_idle("idle_b2b");
    check("total_b2b", 64'(rd_total_sent), 64'h18A);

    // Ordering across distinct clients
    for (int i = 1; i <= 3; i++) push(5'(i), 32'(i * 32'h11), waited);
    wait_idle("idle_order");
    rd_client_id = 5'd2;
    #1 check("total_c2", 64'(rd_total_sent), 64'h22);

    // Full FIFO: one message in the holding registers plus FIFO_DEPTH queued
    do_reset();
    ack_mode = 0;
    for (int i = 0; i < 5; i++) begin
      push(5'(10 + i), 32'(32'h100 + i), waited);
      check("full_no_wait", 64'(waited), 64'd0);
    end
    repeat (3) @(negedge clk);
    check("full_ready_low", 64'(req_ready), 64'd0);
    ack_mode = 1;
    push(5'd15, 32'h105, waited);
    check("held_off", 64'(waited > 0), 64'd1);
    wait_idle("idle_full");
    rd_client_id = 5'd15;
    #1 check("total_c15", 64'(rd_total_sent), 64'h105);

    // Wrap
    do_reset();
    ack_mode = 1;
    rd_client_id = 5'd3;
    push(5'd3, 32'hFFFF_FFF0, waited);
    wait_idle("idle_prime");
    push(5'd3, 32'h20, waited);
    wait_idle("idle_wrap");
    check("total_wrap", 64'(rd_total_sent), 64'h10);

    // Timeout behaviour; ack only ever high while tx_valid is low
    do_reset();
    sb_en = 1'b0;
    ack_mode = 2;
    rd_client_id = 5'd7;
    rise_cnt = 0; drop_cnt = 0; gap_bad = 0; hi_bad = 0;
    push(5'd7, 32'h77, waited);
`ifdef UPSTREAM_RETRY_EN
    wait_idle("idle_retry");
    check("retry_presentations", 64'(rise_cnt), 64'd4);
    check("retry_gaps", 64'(gap_bad), 64'd0);
    check("retry_hold_len", 64'(hi_bad), 64'd0);
    check("retry_drop_cnt", 64'(drop_cnt), 64'd1);
    check("retry_table", 64'(rd_total_sent), 64'd0);
`else
    repeat (80) @(negedge clk);
    check("noretry_tx_held", 64'(tx_valid), 64'd1);
    check("noretry_presentations", 64'(rise_cnt), 64'd1);
    check("noretry_drop", 64'(drop_cnt), 64'd0);
    check("noretry_busy", 64'(busy), 64'd1);
    check("noretry_table", 64'(rd_total_sent), 64'd0);
`endif

    // Reset mid-transfer with two requests queued
    do_reset();
    sb_en = 1'b1;
    ack_mode = 1;
    rd_client_id = 5'd5;
    push(5'd5, 32'h55, waited);
    wait_idle("idle_prime5");
    check("total_c5", 64'(rd_total_sent), 64'h55);
    ack_mode = 0;
    push(5'd6, 32'h66, waited);
    push(5'd8, 32'h88, waited);
    push(5'd9, 32'h99, waited);
    repeat (3) @(negedge clk);
    check("pre_rst_tx_valid", 64'(tx_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_total", 64'(rd_total_sent), 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    check("mid_rst_tx_fields", 64'({tx_client_id, tx_amount}), 64'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rise_cnt = 0;
    ack_mode = 1;
    repeat (20) @(negedge clk);
    check("no_tx_after_rst", 64'(rise_cnt), 64'd0);
    check("idle_after_rst", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
